// File: rtl/count_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : count_uart_tx_if
// Description : Byte handshake and serial-side status bundle for count_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface count_uart_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx,
        output busy,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/count_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : count_uart_tx
// Description : 8N1 LSB-first UART transmitter; optional even parity bit
//               enabled by defining COUNT_UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    count_uart_tx_if.slave bus
);

    localparam int                 c_cnt_w      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last       = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic               c_one_cycle  = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef COUNT_UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shreg;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_in_ready;
    logic                 r_frame_done;
`ifdef COUNT_UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_accept;
    logic w_bit_end;
    logic w_pre_last;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_bit_end  = (r_cnt == c_last);
    // Only evaluated when r_cnt < c_last, so the increment cannot overflow.
    assign w_pre_last = ((r_cnt + 1'b1) == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b0;
`ifdef COUNT_UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                // in_ready is only high in IDLE or the last stop cycle, so an
                // accept always starts a fresh start bit on the next cycle.
                r_state    <= S_START;
                r_cnt      <= '0;
                r_bit_idx  <= '0;
                r_shreg    <= bus.in_data;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
                r_in_ready <= 1'b0;
`ifdef COUNT_UART_TX_PARITY_EN
                r_parity   <= ^bus.in_data;
`endif
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_tx       <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_tx    <= r_shreg[0];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_cnt <= '0;
                            if (r_bit_idx == 3'd7) begin
`ifdef COUNT_UART_TX_PARITY_EN
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
`else
                                r_state      <= S_STOP;
                                r_tx         <= 1'b1;
                                r_frame_done <= c_one_cycle;
                                r_in_ready   <= c_one_cycle;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_shreg   <= {1'b0, r_shreg[7:1]};
                                r_tx      <= r_shreg[1];
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`ifdef COUNT_UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_state      <= S_STOP;
                            r_cnt        <= '0;
                            r_tx         <= 1'b1;
                            r_frame_done <= c_one_cycle;
                            r_in_ready   <= c_one_cycle;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_bit_end) begin
                            r_state    <= S_IDLE;
                            r_cnt      <= '0;
                            r_tx       <= 1'b1;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            // Flag the final stop cycle one edge early so both
                            // outputs stay registered.
                            if (w_pre_last) begin
                                r_frame_done <= 1'b1;
                                r_in_ready   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_tx       <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.in_ready   = r_in_ready;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_count_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_uart_tx
// Description : Directed self-checking bench for count_uart_tx, CLKS_PER_BIT=4.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_count_uart_tx;

    localparam int CPB   = 4;
`ifdef COUNT_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int NCYC  = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count_uart_tx_if bus ();

    count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit j of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0)                    return 1'b0;
        else if (j <= 8)               return b[j-1];
        else if (j == 9 && NBITS == 11) return ^b;
        else                           return 1'b1;
    endfunction

    // Entered #1 after the accepting edge; returns at the negedge of the last frame cycle.
    task automatic watch_frame(input string tag, input logic [7:0] b);
        int fd_cnt   = 0;
        int fd_at    = -1;
        int rdy_cnt  = 0;
        int rdy_at   = -1;
        int tx_bad   = 0;
        int busy_low = 0;
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            if (bus.tx !== exp_bit(b, k / CPB)) tx_bad++;
            if (k % CPB == CPB / 2)
                check($sformatf("%s_bit%0d", tag, k / CPB), 32'(bus.tx), 32'(exp_bit(b, k / CPB)));
            if (bus.frame_done) begin fd_cnt++;  fd_at  = k; end
            if (bus.in_ready)   begin rdy_cnt++; rdy_at = k; end
            if (!bus.busy) busy_low++;
        end
        check({tag, "_tx_cycles_bad"}, tx_bad, 0);
        check({tag, "_fd_count"},      fd_cnt, 1);
        check({tag, "_fd_cycle"},      fd_at, NCYC - 1);
        check({tag, "_rdy_count"},     rdy_cnt, 1);
        check({tag, "_rdy_cycle"},     rdy_at, NCYC - 1);
        check({tag, "_busy_low"},      busy_low, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"},    32'(bus.tx), 1);
        check({tag, "_rdy"},   32'(bus.in_ready), 1);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_fd"},    32'(bus.frame_done), 0);
    endtask

    initial begin
        int         idle_bad;
        int         post_bad;
        logic [7:0] last_data;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state and idle stability
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0)
                idle_bad++;
        end
        check("idle_stable", idle_bad, 0);
        check_idle("idle20");

        // Single byte 0x55
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hFF;
        watch_frame("b55", 8'h55);
        @(negedge clk);
        check_idle("after55");

        // Back-to-back 0xA5 then 0x3C with in_valid held
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_data  = 8'h3C;
        watch_frame("bA5", 8'hA5);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        watch_frame("b3C", 8'h3C);
        @(negedge clk);
        check_idle("after3C");

        // 0x00 frame with in_valid held and in_data churning every cycle
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        last_data = 8'h00;
        fork
            watch_frame("b00", 8'h00);
            begin
                for (int i = 0; i < NCYC; i++) begin
                    last_data   = 8'(i * 29 + 3);
                    bus.in_data = last_data;
                    @(posedge clk); #1;
                end
            end
        join
        bus.in_valid = 1'b0;
        watch_frame("bnext", last_data);
        @(negedge clk);
        check_idle("afternext");

        // Reset pulse at cycle 15 of a 0x00 frame
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_rst_tx", 32'(bus.tx), 0);
        check("pre_rst_busy", 32'(bus.busy), 1);
        #1 rst = 1'b1;
        #1;
        check_idle("mid_rst");
        #1 rst = 1'b0;
        post_bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.frame_done !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) post_bad++;
        end
        check("post_rst_quiet", post_bad, 0);
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        watch_frame("bFF", 8'hFF);
        @(negedge clk);
        check_idle("afterFF");

        // Parity polarity (plain 8N1 frames in the default build)
        bus.in_data  = 8'h07;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        watch_frame("b07", 8'h07);
        @(negedge clk);
        bus.in_data  = 8'h03;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        watch_frame("b03", 8'h03);
        @(negedge clk);
        check_idle("after03");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
